layer_mac_sequencer: RTL and testbench
======================================

Name: layer_mac_sequencer

Overview:
Parametrised per-layer MAC sequencer for the neural-network datapath. It counts accepted input elements per neuron and produces input and neuron indices for weight/activation addressing. It emits accumulator clear, last-element and neuron-complete strobes to the MAC unit, and it signals layer completion to the next layer through a start/done handshake.

Parameters:
N_INPUTS, 3, input elements per neuron (>=1)
N_NEURONS, 4, neurons in the layer (>=1)
IN_W, 2, width of in_idx; 2^IN_W >= N_INPUTS
NEU_W, 2, width of neu_idx; 2^NEU_W >= N_NEURONS

Ports:
clk  input  1  clock; all state updates on the falling edge
rst  input  1  reset
start  input  1  begin a layer pass; sampled in IDLE or DONE only
abort  input  1  cancel an in-progress pass
ack  input  1  current element (in_idx, neu_idx) consumed by the MAC this cycle
in_idx  output  IN_W  current input element index
neu_idx  output  NEU_W  current neuron index
mac_clr  output  1  one-cycle pulse: clear the accumulator before the first element of a neuron
mac_last  output  1  high while the current element is the last of the neuron
ack_mac  output  1  one-cycle pulse: neuron result complete
layer_done  output  1  sticky: all neurons complete
busy  output  1  high in RUN

Behaviour:
- Reset: rst is synchronous and active-high, and it has priority over every other input. On reset, state=IDLE and in_idx=0, neu_idx=0, mac_clr=0, mac_last=0, ack_mac=0, layer_done=0, busy=0.
- All outputs are registered. No combinational path from any input to any output.
- States: IDLE, RUN, DONE.
- IDLE: ack and abort are ignored. When start=1:
  - state goes to RUN; in_idx=0 and neu_idx=0.
  - mac_clr=1 for exactly one cycle.
  - mac_last=(N_INPUTS==1).
- RUN: busy=1 and start is ignored. Priority is abort, then ack.
  - abort=1: state goes to IDLE. Indices return to 0. mac_last=0 and busy=0. No ack_mac, and layer_done stays 0.
  - ack=1 with in_idx<N_INPUTS-1: in_idx increments.
  - ack=1 with in_idx==N_INPUTS-1:
    - in_idx returns to 0.
    - ack_mac=1 for the following cycle only.
    - If neu_idx<N_NEURONS-1: neu_idx increments and mac_clr=1 for one cycle.
    - If neu_idx==N_NEURONS-1: state goes to DONE, layer_done=1, busy=0, and neu_idx holds its final value.
  - ack=0: everything holds. Gaps of any length between acks are legal.
- mac_last always equals (state==RUN && next in_idx==N_INPUTS-1). It is updated on the same edge as in_idx. With N_INPUTS=1 it is constant 1 throughout RUN.
- mac_clr and ack_mac are pulses and deassert on the next edge unless re-triggered. Back-to-back neuron completions with N_INPUTS=1 therefore hold both outputs high for consecutive cycles.
- DONE: layer_done=1 and all indices hold. ack and abort are ignored.
  - start=1 clears layer_done and restarts exactly as from IDLE, including the mac_clr pulse.
- Latency: ack sampled at edge k on the last element gives ack_mac high between edge k and edge k+1.
- Index wrap: in_idx never exceeds N_INPUTS-1 and neu_idx never exceeds N_NEURONS-1, even when 2^W is larger than the parameter.

Test Plan:
- Defaults, start, then 12 consecutive ack cycles -> ack_mac pulses after acks 3, 6, 9 and 12 (four single-cycle pulses). mac_clr pulses after start and after acks 3, 6 and 9. layer_done rises after ack 12. neu_idx sequence is 0,1,2,3. mac_last is high while in_idx=2.
- Defaults, acks with random 0–5 cycle gaps -> indices hold during gaps; same pulse count and order as the previous scenario.
- Start, 5 acks, then abort asserted together with ack -> IDLE, in_idx=0, neu_idx=0, busy=0, no ack_mac after the abort edge, layer_done=0.
- Start asserted in RUN after 2 acks -> ignored (in_idx reaches 2 and continues). After DONE, start clears layer_done and a full second pass completes.
- rst asserted mid-run (neu_idx=2, in_idx=1) -> all outputs 0 on the next falling edge. ack held high during reset has no effect.
- N_INPUTS=1, N_NEURONS=3, ack held high for 3 cycles -> ack_mac high for 3 consecutive cycles. mac_last=1 throughout RUN. layer_done rises after the 3rd ack.

Source files
------------

// File: rtl/layer_mac_sequencer.sv
// Per-layer MAC sequencer: walks (neuron, input) indices on accepted acks,
// strobes accumulator clear/last/complete and flags layer completion.
module layer_mac_sequencer #(
  parameter int N_INPUTS  = 3,
  parameter int N_NEURONS = 4,
  parameter int IN_W      = 2,
  parameter int NEU_W     = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic             ack,
  output logic [IN_W-1:0]  in_idx,
  output logic [NEU_W-1:0] neu_idx,
  output logic             mac_clr,
  output logic             mac_last,
  output logic             ack_mac,
  output logic             layer_done,
  output logic             busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [IN_W-1:0]  IN_LAST  = IN_W'(N_INPUTS - 1);
  localparam logic [NEU_W-1:0] NEU_LAST = NEU_W'(N_NEURONS - 1);
  localparam logic             ONE_IN   = (N_INPUTS == 1);

  state_t           state_q, state_d;
  logic [IN_W-1:0]  in_idx_q, in_idx_d;
  logic [NEU_W-1:0] neu_idx_q, neu_idx_d;
  logic             mac_clr_q, mac_clr_d;
  logic             mac_last_q, mac_last_d;
  logic             ack_mac_q, ack_mac_d;
  logic             layer_done_q, layer_done_d;
  logic             busy_q, busy_d;

  always_ff @(negedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      in_idx_q     <= '0;
      neu_idx_q    <= '0;
      mac_clr_q    <= 1'b0;
      mac_last_q   <= 1'b0;
      ack_mac_q    <= 1'b0;
      layer_done_q <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      in_idx_q     <= in_idx_d;
      neu_idx_q    <= neu_idx_d;
      mac_clr_q    <= mac_clr_d;
      mac_last_q   <= mac_last_d;
      ack_mac_q    <= ack_mac_d;
      layer_done_q <= layer_done_d;
      busy_q       <= busy_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    in_idx_d     = in_idx_q;
    neu_idx_d    = neu_idx_q;
    mac_clr_d    = 1'b0;
    mac_last_d   = mac_last_q;
    ack_mac_d    = 1'b0;
    layer_done_d = layer_done_q;
    busy_d       = busy_q;
    unique case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d      = RUN;
          in_idx_d     = '0;
          neu_idx_d    = '0;
          mac_clr_d    = 1'b1;
          mac_last_d   = ONE_IN;
          layer_done_d = 1'b0;
          busy_d       = 1'b1;
        end
      end
      RUN: begin
        if (abort) begin
          state_d    = IDLE;
          in_idx_d   = '0;
          neu_idx_d  = '0;
          mac_last_d = 1'b0;
          busy_d     = 1'b0;
        end else if (ack) begin
          if (in_idx_q == IN_LAST) begin
            in_idx_d  = '0;
            ack_mac_d = 1'b1;
            if (neu_idx_q == NEU_LAST) begin
              state_d      = DONE;
              layer_done_d = 1'b1;
              busy_d       = 1'b0;
              mac_last_d   = 1'b0;
            end else begin
              neu_idx_d  = neu_idx_q + 1'b1;
              mac_clr_d  = 1'b1;
              mac_last_d = ONE_IN;
            end
          end else begin
            in_idx_d   = in_idx_q + 1'b1;
            mac_last_d = (in_idx_d == IN_LAST);
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign in_idx     = in_idx_q;
  assign neu_idx    = neu_idx_q;
  assign mac_clr    = mac_clr_q;
  assign mac_last   = mac_last_q;
  assign ack_mac    = ack_mac_q;
  assign layer_done = layer_done_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_layer_mac_sequencer.sv
// Directed bench for layer_mac_sequencer: a 3x4 instance and a
// single-input 1x3 instance, outputs sampled just after the falling edge.
module tb_layer_mac_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       a_rst, a_start, a_abort, a_ack;
  logic [1:0] a_in_idx, a_neu_idx;
  logic       a_mac_clr, a_mac_last, a_ack_mac, a_layer_done, a_busy;

  logic       b_rst, b_start, b_abort, b_ack;
  logic [0:0] b_in_idx;
  logic [1:0] b_neu_idx;
  logic       b_mac_clr, b_mac_last, b_ack_mac, b_layer_done, b_busy;

  int n_checks = 0;
  int n_errors = 0;

  layer_mac_sequencer #(
    .N_INPUTS(3), .N_NEURONS(4), .IN_W(2), .NEU_W(2)
  ) u_a (
    .clk(clk), .rst(a_rst), .start(a_start), .abort(a_abort),
    .ack(a_ack), .in_idx(a_in_idx), .neu_idx(a_neu_idx),
    .mac_clr(a_mac_clr), .mac_last(a_mac_last), .ack_mac(a_ack_mac),
    .layer_done(a_layer_done), .busy(a_busy)
  );

  layer_mac_sequencer #(
    .N_INPUTS(1), .N_NEURONS(3), .IN_W(1), .NEU_W(2)
  ) u_b (
    .clk(clk), .rst(b_rst), .start(b_start), .abort(b_abort),
    .ack(b_ack), .in_idx(b_in_idx), .neu_idx(b_neu_idx),
    .mac_clr(b_mac_clr), .mac_last(b_mac_last), .ack_mac(b_ack_mac),
    .layer_done(b_layer_done), .busy(b_busy)
  );

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic a_expect(input string tag, input int e_in, input int e_neu,
                          input int e_clr, input int e_last, input int e_am,
                          input int e_done, input int e_busy);
    chk({tag, "_in"},   32'(a_in_idx),     e_in);
    chk({tag, "_neu"},  32'(a_neu_idx),    e_neu);
    chk({tag, "_clr"},  32'(a_mac_clr),    e_clr);
    chk({tag, "_last"}, 32'(a_mac_last),   e_last);
    chk({tag, "_am"},   32'(a_ack_mac),    e_am);
    chk({tag, "_done"}, 32'(a_layer_done), e_done);
    chk({tag, "_busy"}, 32'(a_busy),       e_busy);
  endtask

  // Expected 3x4 outputs after i accepted acks; pulse=0 inside a gap.
  task automatic a_pos(input string tag, input int i, input bit pulse);
    int e_clr, e_am;
    e_clr = (pulse && (i % 3 == 0) && i < 12) ? 1 : 0;
    e_am  = (pulse && (i % 3 == 0) && i > 0) ? 1 : 0;
    a_expect($sformatf("%s_%0d", tag, i), i % 3,
             (i >= 12) ? 3 : i / 3, e_clr,
             (i < 12 && i % 3 == 2) ? 1 : 0, e_am,
             (i >= 12) ? 1 : 0, (i < 12) ? 1 : 0);
  endtask

  task automatic a_reset();
    a_rst = 1'b1; a_start = 1'b0; a_abort = 1'b0; a_ack = 1'b0;
    tick();
    a_rst = 1'b0;
  endtask

  task automatic a_go();
    a_start = 1'b1;
    tick();
    a_start = 1'b0;
  endtask

  task automatic a_acks(input string tag, input int from, input int to);
    a_ack = 1'b1;
    for (int i = from; i <= to; i++) begin
      tick();
      a_pos(tag, i, 1'b1);
    end
    a_ack = 1'b0;
  endtask

  int gaps[12] = '{0, 1, 5, 2, 0, 3, 4, 1, 0, 5, 2, 3};

  initial begin
    a_rst = 1'b1; a_start = 1'b0; a_abort = 1'b0; a_ack = 1'b0;
    b_rst = 1'b1; b_start = 1'b0; b_abort = 1'b0; b_ack = 1'b0;
    tick();
    tick();
    a_expect("rst", 0, 0, 0, 0, 0, 0, 0);
    chk("b_rst_busy", 32'(b_busy), 0);
    chk("b_rst_last", 32'(b_mac_last), 0);

    // Back-to-back acks through a full layer
    a_rst = 1'b0;
    a_ack = 1'b1;
    tick();
    a_expect("idle_ack", 0, 0, 0, 0, 0, 0, 0);
    a_ack = 1'b0;
    a_go();
    a_pos("s1", 0, 1'b1);
    a_acks("s1", 1, 12);
    tick();
    a_pos("s1_after", 12, 1'b0);

    // Acks separated by gaps
    a_reset();
    a_go();
    a_pos("s2", 0, 1'b1);
    for (int k = 0; k < 12; k++) begin
      for (int g = 0; g < gaps[k]; g++) begin
        tick();
        a_pos("s2_gap", k, 1'b0);
      end
      a_ack = 1'b1;
      tick();
      a_pos("s2", k + 1, 1'b1);
      a_ack = 1'b0;
    end

    // Abort together with ack
    a_reset();
    a_go();
    a_acks("s3", 1, 5);
    a_abort = 1'b1;
    a_ack = 1'b1;
    tick();
    a_expect("s3_abort", 0, 0, 0, 0, 0, 0, 0);
    a_abort = 1'b0;
    tick();
    a_expect("s3_post", 0, 0, 0, 0, 0, 0, 0);
    a_ack = 1'b0;

    // Start ignored in RUN; abort ignored in DONE; restart from DONE
    a_reset();
    a_go();
    a_acks("s4", 1, 2);
    a_start = 1'b1;
    a_ack = 1'b1;
    tick();
    a_pos("s4_start_run", 3, 1'b1);
    a_start = 1'b0;
    a_acks("s4", 4, 12);
    a_abort = 1'b1;
    a_ack = 1'b1;
    tick();
    a_pos("s4_done_abort", 12, 1'b0);
    a_abort = 1'b0;
    a_ack = 1'b0;
    a_go();
    a_pos("s4_restart", 0, 1'b1);
    a_acks("s4b", 1, 12);

    // Reset mid-run with ack held high
    a_reset();
    a_go();
    a_acks("s5", 1, 7);
    a_ack = 1'b1;
    a_rst = 1'b1;
    tick();
    a_expect("s5_rst", 0, 0, 0, 0, 0, 0, 0);
    tick();
    a_expect("s5_rst2", 0, 0, 0, 0, 0, 0, 0);
    a_rst = 1'b0;
    tick();
    a_expect("s5_post", 0, 0, 0, 0, 0, 0, 0);
    a_ack = 1'b0;

    // Single-input layer: consecutive ack_mac pulses
    b_rst = 1'b0;
    b_start = 1'b1;
    tick();
    b_start = 1'b0;
    chk("b_go_clr", 32'(b_mac_clr), 1);
    chk("b_go_last", 32'(b_mac_last), 1);
    chk("b_go_busy", 32'(b_busy), 1);
    chk("b_go_am", 32'(b_ack_mac), 0);
    b_ack = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      tick();
      chk($sformatf("b_am_%0d", i), 32'(b_ack_mac), 1);
      chk($sformatf("b_neu_%0d", i), 32'(b_neu_idx), (i < 3) ? i : 2);
      chk($sformatf("b_in_%0d", i), 32'(b_in_idx), 0);
      chk($sformatf("b_clr_%0d", i), 32'(b_mac_clr), (i < 3) ? 1 : 0);
      chk($sformatf("b_last_%0d", i), 32'(b_mac_last), (i < 3) ? 1 : 0);
      chk($sformatf("b_done_%0d", i), 32'(b_layer_done), (i == 3) ? 1 : 0);
      chk($sformatf("b_busy_%0d", i), 32'(b_busy), (i < 3) ? 1 : 0);
    end
    b_ack = 1'b0;
    tick();
    chk("b_after_am", 32'(b_ack_mac), 0);
    chk("b_after_done", 32'(b_layer_done), 1);

    $display("Simulation finished: %0d checks, %0d errors",
             n_checks, n_errors);
    $finish;
  end

endmodule
